// File: rtl/riscv_hazard_unit.sv
// Hazard detection and control for the 5-stage RISC-V pipeline.
// The fetch-enable and flush/bubble controls are purely combinational.
// Two clocked counters record load-use stall cycles and control-flush
// cycles for performance monitoring.
module riscv_hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_reg1_idx,
    input  logic [4:0]       id_reg2_idx,
    input  logic             pc_jump_enable,
    input  logic [4:0]       ex_reg_wr_idx,
    input  logic             ex_do_mem_read_en,
    output logic             hazard_fe_enable,
    output logic             hazard_if_id_clear,
    output logic             hazard_id_ex_clear,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             load_use_s;
    logic             ctrl_s;
    logic             stall_evt_s;
    logic             flush_evt_s;
    logic [CNT_W-1:0] stall_count_r;
    logic [CNT_W-1:0] flush_count_r;

    // Detect a load in EX whose destination feeds either ID source (never x0).
    always_comb begin
        load_use_s = 1'b0;
        if (ex_do_mem_read_en && (ex_reg_wr_idx != 5'd0) &&
            ((ex_reg_wr_idx == id_reg1_idx) || (ex_reg_wr_idx == id_reg2_idx))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    assign ctrl_s = pc_jump_enable;

    // Prioritised pipeline controls: redirect beats load-use, which beats idle.
    always_comb begin
        hazard_fe_enable   = 1'b1;
        hazard_if_id_clear = 1'b0;
        hazard_id_ex_clear = 1'b0;
        stall_evt_s        = 1'b0;
        flush_evt_s        = 1'b0;
        if (ctrl_s) begin
            // Wrong-path instructions in IF/ID and ID/EX are both squashed.
            hazard_fe_enable   = 1'b1;
            hazard_if_id_clear = 1'b1;
            hazard_id_ex_clear = 1'b1;
            flush_evt_s        = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID; send one bubble into EX.
            hazard_fe_enable   = 1'b0;
            hazard_if_id_clear = 1'b0;
            hazard_id_ex_clear = 1'b1;
            stall_evt_s        = 1'b1;
        end else begin
            hazard_fe_enable   = 1'b1;
            hazard_if_id_clear = 1'b0;
            hazard_id_ex_clear = 1'b0;
        end
    end

    // Event counters; reset is checked first so X controls cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= CNT_ZERO;
            flush_count_r <= CNT_ZERO;
        end else begin
            if (stall_evt_s) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (flush_evt_s) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed self-checking bench for riscv_hazard_unit. Expected control
// values are queued when each step is driven and popped when the
// combinational outputs have settled; counter expectations are tracked
// alongside and checked one edge later.
module tb_riscv_hazard_unit;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic fe;
        logic ifid;
        logic idex;
    } ctl_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_reg1_idx;
    logic [4:0]       id_reg2_idx;
    logic             pc_jump_enable;
    logic [4:0]       ex_reg_wr_idx;
    logic             ex_do_mem_read_en;
    logic             hazard_fe_enable;
    logic             hazard_if_id_clear;
    logic             hazard_id_ex_clear;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int               errors;
    int               checks;
    ctl_t             exp_q[$];
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;

    riscv_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_reg1_idx       (id_reg1_idx),
        .id_reg2_idx       (id_reg2_idx),
        .pc_jump_enable    (pc_jump_enable),
        .ex_reg_wr_idx     (ex_reg_wr_idx),
        .ex_do_mem_read_en (ex_do_mem_read_en),
        .hazard_fe_enable  (hazard_fe_enable),
        .hazard_if_id_clear(hazard_if_id_clear),
        .hazard_id_ex_clear(hazard_id_ex_clear),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One directed cycle: drive, check controls via queue, clock, check counters.
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] exrd, input logic memrd, input logic jmp,
                        input logic efe, input logic eifid, input logic eidex);
        ctl_t e;
        ctl_t got;
        @(negedge clk);
        rst               = r;
        id_reg1_idx       = rs1;
        id_reg2_idx       = rs2;
        ex_reg_wr_idx     = exrd;
        ex_do_mem_read_en = memrd;
        pc_jump_enable    = jmp;
        e.fe = efe; e.ifid = eifid; e.idex = eidex;
        exp_q.push_back(e);
        #1;
        got.fe = hazard_fe_enable; got.ifid = hazard_if_id_clear; got.idex = hazard_id_ex_clear;
        e = exp_q.pop_front();
        check({tag, "_ctl"}, {{(CNT_W-3){1'b0}}, got}, {{(CNT_W-3){1'b0}}, e});
        @(posedge clk);
        if (r) begin
            exp_stall = '0;
            exp_flush = '0;
        end else if (eifid) begin
            exp_flush = exp_flush + 32'd1;
        end else if (!efe) begin
            exp_stall = exp_stall + 32'd1;
        end else begin
            exp_stall = exp_stall;
        end
        #1;
        check({tag, "_stall_cnt"}, stall_count, exp_stall);
        check({tag, "_flush_cnt"}, flush_count, exp_flush);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_stall = '0;
        exp_flush = '0;
        rst = 1'b1;
        id_reg1_idx = 5'd0; id_reg2_idx = 5'd0; ex_reg_wr_idx = 5'd0;
        ex_do_mem_read_en = 1'b0; pc_jump_enable = 1'b0;

        // Reset, with controls still following the combinational rules.
        step("rst_idle",   1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst_stall",  1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // No hazard, counters must hold.
        step("nohaz0",     1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("nohaz1",     1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Register match without a load is not a hazard.
        step("nomemrd",    1'b0, 5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Load-use on rs1, counted every edge.
        step("lu_rs1_0",   1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_rs1_1",   1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_rs1_2",   1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Control hazard.
        step("ctrl0",      1'b0, 5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("ctrl1",      1'b0, 5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Load to x0 never stalls, even when an ID source is x0.
        step("ld_x0",      1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Match on rs2 only.
        step("lu_rs2",     1'b0, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Load-use on x31 via rs1.
        step("lu_x31",     1'b0, 5'd31, 5'd4, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Jump together with load-use counts only as a flush.
        step("jmp_lu0",    1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("jmp_lu1",    1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset mid-stall clears counters; controls still stall.
        step("rst_mid",    1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("post_rst",   1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("post_rst_j", 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // X on the controls while in reset must not reach the counters.
        @(negedge clk);
        rst = 1'b1;
        id_reg1_idx = 5'bx; id_reg2_idx = 5'bx; ex_reg_wr_idx = 5'bx;
        ex_do_mem_read_en = 1'bx; pc_jump_enable = 1'bx;
        @(posedge clk);
        #1;
        check("x_rst_stall_cnt", stall_count, 32'd0);
        check("x_rst_flush_cnt", flush_count, 32'd0);
        exp_stall = '0;
        exp_flush = '0;
        step("after_x",    1'b0, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
